uart_dbg_ctrl: RTL and testbench
================================

UART_DBG_CTRL -- requirements
Module: uart_dbg_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'hFFFF, cycles to wait for mem_ack before error.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- rx_vld  in  1  received-byte pulse from UART receiver
- rx_data  in  8  received byte, valid with rx_vld
- rx_rdy  out  1  controller accepts received bytes
- tx_vld  out  1  byte offered to UART transmitter
- tx_data  out  8  byte to send, stable while tx_vld=1
- tx_rdy  in  1  transmitter accepts byte
- mem_rd  out  1  one-cycle read request
- mem_addr  out  32  read address, held until the response is finished
- mem_ack  in  1  read-data-valid pulse
- mem_rdata  in  32  read data, valid with mem_ack
- busy  out  1  high in any state other than IDLE
- err_cnt  out  8  saturating count of error responses
REQ-003 SHALL use the decided clocking: reset reset, synchronous, active-high; clock clk.

Function
REQ-004 SHALL parse the command 'R' (0x52 or 0x72), exactly 8 ASCII hex digits (MSB first; 0-9, A-F, a-f), then CR (0x0D).
REQ-005 SHALL implement states IDLE, ADDR, EOL, MEM_REQ, MEM_WAIT, SEND, ERR_SEND.
REQ-006 IDLE: 'R'/'r' -> ADDR with the address shift register cleared; CR or LF -> stay in IDLE; any other byte -> ERR_SEND.
REQ-007 ADDR: on a hex digit, shift the nibble into the address (addr <= {addr[27:0], nib}) and increment the digit count; after the 8th digit -> EOL; on a non-hex byte, including an early CR -> ERR_SEND.
REQ-008 EOL: CR -> MEM_REQ; any other byte -> ERR_SEND.
REQ-009 rx_rdy SHALL be 1 only in IDLE, ADDR and EOL; rx_vld while rx_rdy=0 SHALL be dropped with no effect.
REQ-010 MEM_REQ: mem_rd=1 for exactly one cycle with mem_addr valid; next state MEM_WAIT.
REQ-011 MEM_WAIT: on mem_ack, capture mem_rdata -> SEND; a 16-bit counter expiring after TIMEOUT cycles without mem_ack -> ERR_SEND.
REQ-012 SEND SHALL transmit 10 bytes: 8 uppercase hex digits of the captured data, MSB nibble first, then 0x0D and 0x0A; then go to IDLE.
REQ-013 ERR_SEND SHALL transmit '?' (0x3F), 0x0D, 0x0A; increment err_cnt (saturating at 255); then go to IDLE.
REQ-014 A tx byte SHALL transfer on a clock edge where tx_vld=1 and tx_rdy=1; the next byte SHALL be presented on the following cycle; tx_data SHALL NOT change while tx_vld=1 and tx_rdy=0.
REQ-015 mem_ack outside MEM_WAIT SHALL be ignored; mem_ack in the same cycle as timeout expiry SHALL win (go to SEND).
REQ-016 Latency: mem_rd SHALL assert 1 cycle after the CR is accepted; first tx_vld SHALL assert 1 cycle after mem_ack.

Reset
REQ-017 On reset: state=IDLE, rx_rdy=1 from the first cycle after reset, tx_vld=0, tx_data=0, mem_rd=0, mem_addr=0, busy=0, err_cnt=0, counters=0.
REQ-018 Reset mid-operation SHALL abort the command immediately with no further tx byte or mem_rd.

Structure
REQ-019 Package uart_dbg_pkg SHALL hold the state enum, the ASCII constants (CR, LF, 'R', '?') and the hex-to-nibble / nibble-to-ASCII functions.
REQ-020 SHALL be a single module with no sub-module; it connects beside the existing UART receiver/transmitter pair.

Verification
REQ-021 "R0000ABCD\r", mem_ack after 3 cycles with rdata=32'hDEADBEEF -> mem_addr=0000ABCD, one mem_rd pulse, tx "DEADBEEF\r\n".
REQ-022 "r12ab\r" (early CR) -> no mem_rd, tx "?\r\n", err_cnt=1.
REQ-023 Valid command, mem_ack never arrives, TIMEOUT=16 -> ERR_SEND after 16 cycles, tx "?\r\n".
REQ-024 tx_rdy held low for 50 cycles mid-response -> tx_data stable, no byte lost or duplicated.
REQ-025 Reset asserted during SEND after byte 4 -> tx_vld=0 next cycle, IDLE; then a fresh command completes correctly.
REQ-026 256 bad bytes ('X') -> err_cnt saturates at 255; bytes arriving during ERR_SEND are dropped.

Source files
------------

// File: rtl/uart_dbg_pkg.sv
// Shared types and helpers for the UART debug read controller.
// Holds the controller state encoding, ASCII constants and hex conversion.
// Pure declarations; no timing or flow control of its own.
package uart_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    EOL,
    MEM_REQ,
    MEM_WAIT,
    SEND,
    ERR_SEND
  } state_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_R_UP = 8'h52;
  localparam logic [7:0] ASCII_R_LO = 8'h72;
  localparam logic [7:0] ASCII_QM   = 8'h3F;

  // True for 0-9, A-F, a-f.
  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Only meaningful when is_hex(c); letters share the low nibble 1..6 in both cases.
  function automatic logic [3:0] hex_to_nib(input logic [7:0] c);
    if (c <= 8'h39) return c[3:0];
    else            return c[3:0] + 4'd9;
  endfunction

  // Uppercase ASCII for a nibble.
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'd0, n};
    else           return 8'h37 + {4'd0, n};
  endfunction

endpackage

// File: rtl/uart_dbg_ctrl.sv
// Purpose: parses "R<8 hex>\r" from a UART byte stream, issues one memory read, replies "<8 HEX>\r\n" or "?\r\n".
// Latency: mem_rd 1 cycle after the CR is accepted; first tx_vld 1 cycle after mem_ack; one tx byte per cycle when tx_rdy=1.
// Backpressure: rx_rdy=0 outside IDLE/ADDR/EOL (bytes dropped); tx_data held while tx_vld=1 and tx_rdy=0.
// Ports: clk/reset (sync, active-high); rx_vld/rx_data/rx_rdy from the UART receiver;
//        tx_vld/tx_data/tx_rdy to the UART transmitter; mem_rd/mem_addr/mem_ack/mem_rdata read port;
//        busy (not IDLE); err_cnt (saturating count of error replies).
module uart_dbg_ctrl
  import uart_dbg_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_vld,
  input  logic [7:0]  rx_data,
  output logic        rx_rdy,
  output logic        tx_vld,
  output logic [7:0]  tx_data,
  input  logic        tx_rdy,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  state_t      state;
  logic [31:0] data_q;
  logic [2:0]  dig_cnt;
  logic [15:0] tmo_cnt;
  logic [3:0]  tx_idx;
  logic        go_err;
  logic        tx_xfer;

  // Byte i of the read reply: 8 hex digits MSB first, then CR, LF.
  function automatic logic [7:0] reply_char(input logic [31:0] d, input logic [3:0] i);
    logic [31:0] sh;
    sh = d << {i[2:0], 2'b00};
    if (i < 4'd8)       return nib_to_ascii(sh[31:28]);
    else if (i == 4'd8) return ASCII_CR;
    else                return ASCII_LF;
  endfunction

  assign rx_rdy  = (state == IDLE) || (state == ADDR) || (state == EOL);
  assign busy    = (state != IDLE);
  assign tx_xfer = tx_vld && tx_rdy;

  // Every path into the error reply; rx_vld only matters in states where rx_rdy=1.
  // A same-cycle mem_ack beats the timeout.
  always_comb begin
    go_err = 1'b0;
    case (state)
      IDLE:     go_err = rx_vld && (rx_data != ASCII_R_UP) && (rx_data != ASCII_R_LO) &&
                         (rx_data != ASCII_CR) && (rx_data != ASCII_LF);
      ADDR:     go_err = rx_vld && !is_hex(rx_data);
      EOL:      go_err = rx_vld && (rx_data != ASCII_CR);
      MEM_WAIT: go_err = !mem_ack && (tmo_cnt == TIMEOUT - 16'd1);
      default:  go_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_vld   <= 1'b0;
      tx_data  <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      err_cnt  <= '0;
      data_q   <= '0;
      dig_cnt  <= '0;
      tmo_cnt  <= '0;
      tx_idx   <= '0;
    end else begin
      mem_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_vld && ((rx_data == ASCII_R_UP) || (rx_data == ASCII_R_LO))) begin
            state    <= ADDR;
            mem_addr <= '0;
            dig_cnt  <= '0;
          end
        end
        ADDR: begin
          if (rx_vld && is_hex(rx_data)) begin
            mem_addr <= {mem_addr[27:0], hex_to_nib(rx_data)};
            dig_cnt  <= dig_cnt + 3'd1;
            if (dig_cnt == 3'd7) state <= EOL;
          end
        end
        EOL: begin
          if (rx_vld && (rx_data == ASCII_CR)) begin
            state  <= MEM_REQ;
            mem_rd <= 1'b1;
          end
        end
        MEM_REQ: begin
          state   <= MEM_WAIT;
          tmo_cnt <= '0;
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            data_q  <= mem_rdata;
            state   <= SEND;
            tx_vld  <= 1'b1;
            tx_data <= reply_char(mem_rdata, 4'd0);
            tx_idx  <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        SEND: begin
          if (tx_xfer) begin
            if (tx_idx == 4'd9) begin
              tx_vld <= 1'b0;
              state  <= IDLE;
            end else begin
              tx_idx  <= tx_idx + 4'd1;
              tx_data <= reply_char(data_q, tx_idx + 4'd1);
            end
          end
        end
        ERR_SEND: begin
          if (tx_xfer) begin
            if (tx_idx == 4'd2) begin
              tx_vld <= 1'b0;
              state  <= IDLE;
            end else begin
              tx_idx  <= tx_idx + 4'd1;
              tx_data <= (tx_idx == 4'd0) ? ASCII_CR : ASCII_LF;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Placed after the case so it overrides any partial update above.
      if (go_err) begin
        state   <= ERR_SEND;
        tx_vld  <= 1'b1;
        tx_data <= ASCII_QM;
        tx_idx  <= '0;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_dbg_ctrl.sv
module tb_uart_dbg_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_vld = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rdy;
  logic        tx_vld;
  logic [7:0]  tx_data;
  logic        tx_rdy = 1'b1;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad = 0;
  logic [7:0] txq[$];
  int rd_cnt = 0;

  uart_dbg_ctrl #(.TIMEOUT(16'd16)) dut (
    .clk(clk), .reset(reset),
    .rx_vld(rx_vld), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .tx_vld(tx_vld), .tx_data(tx_data), .tx_rdy(tx_rdy),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Transmitter and memory observers, sampled mid-cycle; the transmitter shares reset.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_vld && tx_rdy) txq.push_back(tx_data);
      if (mem_rd) rd_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!rx_rdy && n < 100) begin tick(); n++; end
    total++;
    if (rx_rdy !== 1'b1) begin
      bad++;
      $display("FAIL send_byte_rdy: rx_rdy=%b required 1 for byte %h", rx_rdy, b);
    end
    rx_vld = 1'b1;
    rx_data = b;
    tick();
    rx_vld = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_tx(input int base, input int n);
    int k = 0;
    while (txq.size() < base + n && k < 400) begin tick(); k++; end
    total++;
    if (txq.size() < base + n) begin
      bad++;
      $display("FAIL wait_tx: got %0d bytes required %0d", txq.size() - base, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total += 7;
    if (rx_rdy  !== 1'b1)  begin bad++; $display("FAIL reset_rx_rdy: %b required 1", rx_rdy); end
    if (tx_vld  !== 1'b0)  begin bad++; $display("FAIL reset_tx_vld: %b required 0", tx_vld); end
    if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: %h required 00", tx_data); end
    if (mem_rd  !== 1'b0)  begin bad++; $display("FAIL reset_mem_rd: %b required 0", mem_rd); end
    if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: %h required 0", mem_addr); end
    if (busy    !== 1'b0)  begin bad++; $display("FAIL reset_busy: %b required 0", busy); end
    if (err_cnt !== 8'h00) begin bad++; $display("FAIL reset_err_cnt: %h required 00", err_cnt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read();
    int base = txq.size();
    int r0 = rd_cnt;
    string exp = "DEADBEEF\r\n";
    send_str("R0000ABCD\r");
    total += 3;
    if (mem_rd !== 1'b1) begin bad++; $display("FAIL read_mem_rd_latency: %b required 1", mem_rd); end
    if (mem_addr !== 32'h0000ABCD) begin bad++; $display("FAIL read_mem_addr: %h required 0000abcd", mem_addr); end
    if (rx_rdy !== 1'b0) begin bad++; $display("FAIL read_rx_rdy_memreq: %b required 0", rx_rdy); end
    repeat (3) tick();
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    total += 2;
    if (tx_vld !== 1'b1) begin bad++; $display("FAIL read_tx_vld_latency: %b required 1", tx_vld); end
    if (tx_data !== 8'h44) begin bad++; $display("FAIL read_first_byte: %h required 44", tx_data); end
    wait_tx(base, 10);
    tick();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (txq[base + i] !== exp[i]) begin
        bad++; $display("FAIL read_tx_byte%0d: %h required %h", i, txq[base + i], exp[i]);
      end
    end
    total += 4;
    if (rd_cnt - r0 != 1) begin bad++; $display("FAIL read_mem_rd_pulses: %0d required 1", rd_cnt - r0); end
    if (busy !== 1'b0) begin bad++; $display("FAIL read_busy_end: %b required 0", busy); end
    if (err_cnt !== 8'd0) begin bad++; $display("FAIL read_err_cnt: %0d required 0", err_cnt); end
    if (txq.size() != base + 10) begin bad++; $display("FAIL read_tx_count: %0d required 10", txq.size() - base); end
  endtask

  task automatic test_early_cr();
    int base = txq.size();
    int r0 = rd_cnt;
    string exp = "?\r\n";
    send_str("r12ab\r");
    wait_tx(base, 3);
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (txq[base + i] !== exp[i]) begin
        bad++; $display("FAIL early_cr_tx_byte%0d: %h required %h", i, txq[base + i], exp[i]);
      end
    end
    total += 3;
    if (rd_cnt != r0) begin bad++; $display("FAIL early_cr_mem_rd: %0d pulses required 0", rd_cnt - r0); end
    if (err_cnt !== 8'd1) begin bad++; $display("FAIL early_cr_err_cnt: %0d required 1", err_cnt); end
    if (busy !== 1'b0) begin bad++; $display("FAIL early_cr_busy: %b required 0", busy); end
  endtask

  task automatic test_timeout();
    int base = txq.size();
    int n = 0;
    string exp = "?\r\n";
    send_str("R00000010\r");
    total += 2;
    if (mem_rd !== 1'b1) begin bad++; $display("FAIL timeout_mem_rd: %b required 1", mem_rd); end
    if (mem_addr !== 32'h10) begin bad++; $display("FAIL timeout_mem_addr: %h required 00000010", mem_addr); end
    // MEM_REQ cycle, then 16 cycles in MEM_WAIT, then the error reply starts.
    while (!tx_vld && n < 40) begin tick(); n++; end
    total++;
    if (n != 17) begin bad++; $display("FAIL timeout_cycles: %0d required 17", n); end
    wait_tx(base, 3);
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (txq[base + i] !== exp[i]) begin
        bad++; $display("FAIL timeout_tx_byte%0d: %h required %h", i, txq[base + i], exp[i]);
      end
    end
    total++;
    if (err_cnt !== 8'd2) begin bad++; $display("FAIL timeout_err_cnt: %0d required 2", err_cnt); end
    // A late ack in IDLE must do nothing.
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0;
    repeat (3) tick();
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL late_ack_busy: %b required 0", busy); end
    if (tx_vld !== 1'b0) begin bad++; $display("FAIL late_ack_tx_vld: %b required 0", tx_vld); end
    if (txq.size() != base + 3) begin bad++; $display("FAIL late_ack_tx_count: %0d required 3", txq.size() - base); end
  endtask

  task automatic test_stall();
    int base = txq.size();
    int k = 0;
    string exp = "0123ABCD\r\n";
    send_str("R00001234\r");
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h0123ABCD;
    tick();
    mem_ack = 1'b0;
    while (txq.size() < base + 4 && k < 50) begin tick(); k++; end
    tx_rdy = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      total++;
      if (tx_vld !== 1'b1 || tx_data !== 8'h41) begin
        bad++; $display("FAIL stall_hold_c%0d: vld=%b data=%h required vld=1 data=41", c, tx_vld, tx_data);
      end
    end
    tx_rdy = 1'b1;
    wait_tx(base, 10);
    repeat (2) tick();
    total++;
    if (txq.size() != base + 10) begin bad++; $display("FAIL stall_tx_count: %0d required 10", txq.size() - base); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (txq[base + i] !== exp[i]) begin
        bad++; $display("FAIL stall_tx_byte%0d: %h required %h", i, txq[base + i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    int base = txq.size();
    int k = 0;
    int r0;
    string exp = "000000A5\r\n";
    send_str("R0000FFFF\r");
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h89ABCDEF;
    tick();
    mem_ack = 1'b0;
    while (txq.size() < base + 4 && k < 50) begin tick(); k++; end
    reset = 1'b1;
    tick();
    total += 5;
    if (tx_vld !== 1'b0) begin bad++; $display("FAIL midrst_tx_vld: %b required 0", tx_vld); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: %b required 0", busy); end
    if (rx_rdy !== 1'b1) begin bad++; $display("FAIL midrst_rx_rdy: %b required 1", rx_rdy); end
    if (err_cnt !== 8'd0) begin bad++; $display("FAIL midrst_err_cnt: %0d required 0", err_cnt); end
    if (mem_addr !== 32'h0) begin bad++; $display("FAIL midrst_mem_addr: %h required 0", mem_addr); end
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    total++;
    if (txq.size() != base + 4) begin bad++; $display("FAIL midrst_tx_count: %0d required 4", txq.size() - base); end
    base = txq.size();
    r0 = rd_cnt;
    send_str("R00000001\r");
    total++;
    if (mem_addr !== 32'h1) begin bad++; $display("FAIL midrst_new_addr: %h required 00000001", mem_addr); end
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h000000A5;
    tick();
    mem_ack = 1'b0;
    wait_tx(base, 10);
    tick();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (txq[base + i] !== exp[i]) begin
        bad++; $display("FAIL midrst_new_byte%0d: %h required %h", i, txq[base + i], exp[i]);
      end
    end
    total++;
    if (rd_cnt - r0 != 1) begin bad++; $display("FAIL midrst_new_pulses: %0d required 1", rd_cnt - r0); end
  endtask

  task automatic test_saturate();
    int base = txq.size();
    string exp = "?\r\n";
    total++;
    if (err_cnt !== 8'd0) begin bad++; $display("FAIL sat_start: %0d required 0", err_cnt); end
    for (int i = 0; i < 256; i++) begin
      int k = 0;
      send_byte(8'h58);
      if (i == 0) begin
        total++;
        if (rx_rdy !== 1'b0) begin bad++; $display("FAIL sat_rx_rdy_errsend: %b required 0", rx_rdy); end
        rx_vld = 1'b1;
        rx_data = 8'h58;
        repeat (2) tick();
        rx_vld = 1'b0;
      end
      while (busy && k < 20) begin tick(); k++; end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL sat_busy_i%0d: %b required 0", i, busy); end
      if (i == 0) begin
        total++;
        if (err_cnt !== 8'd1) begin bad++; $display("FAIL sat_drop_err_cnt: %0d required 1", err_cnt); end
      end
      if (i == 254) begin
        total++;
        if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_at_255: %0d required 255", err_cnt); end
      end
    end
    tick();
    total += 2;
    if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold: %0d required 255", err_cnt); end
    if (txq.size() != base + 768) begin bad++; $display("FAIL sat_tx_count: %0d required 768", txq.size() - base); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (txq[base + 765 + i] !== exp[i]) begin
        bad++; $display("FAIL sat_last_byte%0d: %h required %h", i, txq[base + 765 + i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_early_cr();
    test_timeout();
    test_stall();
    test_reset_mid_send();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
